// File: rtl/ov2640_sccb_writer.sv
// ov2640_sccb_writer
//   Walks the OV2640 register table and writes each {reg, val} entry to the
//   camera as a 3-phase SCCB write: DEV_ADDR, reg, val. It rewinds the table
//   on start, steps it after every write and stops when the table reports
//   finished. ACK slots are driven released and are not sampled.
//
//   Optional build macro: OV2640_SOFT_RESET_DELAY_EN
//     When defined, a write to COM7 (reg 8'h12) with val[7]=1 (soft reset) is
//     followed by a 1 ms hold (CLK_FREQ_HZ/1000 clocks) before the table is
//     stepped. This gives the sensor time to come back out of reset.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     pulse: (re)start the full configuration (ignored while busy)
//   command   {reg[15:8], val[7:0]} from the table
//   finished  table end flag, sampled only when a new entry is checked
//   resend    one-clock pulse: rewind the table
//   advance   one-clock pulse: step the table
//   sioc      SCCB clock, push-pull
//   siod_oe   1 = pull SIOD low, 0 = release to the external pull-up
//   busy      configuration in progress
//   done      table exhausted, held until the next start
//   wr_count  commands written since start, saturating at 511
module ov2640_sccb_writer #(
    parameter int          CLK_FREQ_HZ  = 27000000,
    parameter int          SCCB_FREQ_HZ = 100000,
    parameter logic [7:0]  DEV_ADDR     = 8'h60,
    parameter int          QTR_DIV      = ((CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ)) < 1) ? 1 :
                                          (CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ))
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic [8:0]  wr_count
);

    localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_REWIND  = 4'd1;
    localparam logic [3:0] S_SETTLE  = 4'd2;
    localparam logic [3:0] S_CHECK   = 4'd3;
    localparam logic [3:0] S_START   = 4'd4;
    localparam logic [3:0] S_BITS    = 4'd5;
    localparam logic [3:0] S_STOP    = 4'd6;
    localparam logic [3:0] S_GAP     = 4'd7;
    localparam logic [3:0] S_ADVANCE = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;
`ifdef OV2640_SOFT_RESET_DELAY_EN
    localparam logic [3:0] S_DELAY   = 4'd10;
    localparam int DLY_CLKS = ((CLK_FREQ_HZ / 1000) < 1) ? 1 : (CLK_FREQ_HZ / 1000);
    localparam int DW       = $clog2(DLY_CLKS + 1);
`endif

    logic [3:0]    state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [1:0]    settle_cnt;
    logic [4:0]    bit_idx;     // 0..26 across the three bytes
    logic [3:0]    slot;        // 0..8 within a byte, 8 = ACK slot
    logic [23:0]   shreg;       // MSB is the bit currently on the wire
    logic          qtick, last_q;
    logic          sioc_nxt, oe_nxt;
`ifdef OV2640_SOFT_RESET_DELAY_EN
    logic          is_com7_rst;
    logic [DW-1:0] dly_cnt;
`endif

    assign qtick  = (qcnt == QW'(QTR_DIV - 1));
    assign last_q = qtick && (qtr == 2'd3);

    assign resend  = (state == S_REWIND);
    assign advance = (state == S_ADVANCE);
    assign done    = (state == S_DONE);
    assign busy    = (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_REWIND;
            S_REWIND:       state_nxt = S_SETTLE;
            // table output is registered twice; three clocks covers it
            S_SETTLE:       if (settle_cnt == 2'd2) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = finished ? S_DONE : S_START;
            S_START:        if (last_q) state_nxt = S_BITS;
            S_BITS:         if (last_q && bit_idx == 5'd26) state_nxt = S_STOP;
            S_STOP:         if (last_q) state_nxt = S_GAP;
`ifdef OV2640_SOFT_RESET_DELAY_EN
            S_GAP:          if (last_q) state_nxt = is_com7_rst ? S_DELAY : S_ADVANCE;
            S_DELAY:        if (dly_cnt == DW'(DLY_CLKS - 1)) state_nxt = S_ADVANCE;
`else
            S_GAP:          if (last_q) state_nxt = S_ADVANCE;
`endif
            S_ADVANCE:      state_nxt = S_SETTLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Line levels for the current quarter; registered below so the pins
    // never see decode glitches.
    always_comb begin
        sioc_nxt = 1'b1;
        oe_nxt   = 1'b0;
        case (state)
            S_START: begin
                sioc_nxt = (qtr != 2'd3);
                oe_nxt   = qtr[1];
            end
            S_BITS: begin
                sioc_nxt = qtr[1];
                oe_nxt   = (slot != 4'd8) && !shreg[23];
            end
            S_STOP: begin
                sioc_nxt = (qtr != 2'd0);
                oe_nxt   = !qtr[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            qtr        <= '0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            slot       <= '0;
            shreg      <= '0;
            wr_count   <= '0;
            sioc       <= 1'b1;
            siod_oe    <= 1'b0;
`ifdef OV2640_SOFT_RESET_DELAY_EN
            is_com7_rst <= 1'b0;
            dly_cnt     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            sioc    <= sioc_nxt;
            siod_oe <= oe_nxt;

            // quarter timing restarts on every state change
            if (state_nxt != state) begin
                qcnt <= '0;
                qtr  <= '0;
            end else if (qtick) begin
                qcnt <= '0;
                qtr  <= qtr + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end

            case (state)
                S_IDLE, S_DONE: if (start) wr_count <= '0;
                S_REWIND:  settle_cnt <= '0;
                S_SETTLE:  settle_cnt <= settle_cnt + 2'd1;
                S_CHECK: begin
                    shreg   <= {DEV_ADDR, command};
                    bit_idx <= '0;
                    slot    <= '0;
`ifdef OV2640_SOFT_RESET_DELAY_EN
                    is_com7_rst <= (command[15:8] == 8'h12) && command[7];
`endif
                end
                S_BITS: if (last_q) begin
                    bit_idx <= bit_idx + 5'd1;
                    if (slot == 4'd8) begin
                        slot <= '0;
                    end else begin
                        slot  <= slot + 4'd1;
                        shreg <= {shreg[22:0], 1'b0};
                    end
                end
`ifdef OV2640_SOFT_RESET_DELAY_EN
                S_GAP:   dly_cnt <= '0;
                S_DELAY: dly_cnt <= dly_cnt + DW'(1);
`endif
                S_ADVANCE: begin
                    settle_cnt <= '0;
                    if (wr_count != 9'h1FF) wr_count <= wr_count + 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ov2640_sccb_writer.sv
module tb_ov2640_sccb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] command;
    logic        finished;
    logic        resend, advance, sioc, siod_oe, busy, done;
    logic [8:0]  wr_count;

    always #5 clk = ~clk;

    ov2640_sccb_writer #(
        .CLK_FREQ_HZ (4000000),
        .SCCB_FREQ_HZ(100000),
        .DEV_ADDR    (8'h60)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .command(command), .finished(finished),
        .resend(resend), .advance(advance), .sioc(sioc), .siod_oe(siod_oe),
        .busy(busy), .done(done), .wr_count(wr_count)
    );

`ifdef OV2640_SOFT_RESET_DELAY_EN
    localparam int SOFT_DLY = 4000;
`else
    localparam int SOFT_DLY = 0;
`endif
    // QTR_DIV=10. START entered at t0; SIOD pulled low in START q2 (t0+20),
    // seen on the registered pin at t0+21. ADVANCE at t0+1200 (frame+GAP).
    localparam int START_TO_ADV = 1200 - 21;
    // REWIND at r, SETTLE r+1..r+3, CHECK r+4, START r+5 -> SIOD low at r+26.
    localparam int RESEND_TO_SDA = 26;

    // register table model: two-clock latency from resend/advance
    logic [15:0] tbl [3];
    int unsigned idx = 0;
    logic [15:0] cmd_r = 16'h0000;
    initial begin
        tbl[0] = 16'hFF01; tbl[1] = 16'h1280; tbl[2] = 16'hFFFF;
    end
    always @(posedge clk) begin
        if (resend)       idx <= 0;
        else if (advance) idx <= (idx < 2) ? idx + 1 : idx;
        cmd_r <= tbl[idx];
    end
    assign command  = cmd_r;
    assign finished = (cmd_r == 16'hFFFF);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [23:0] exp_q[$];

    // ---------------- monitor ----------------
    logic prev_sioc = 1'b1, prev_oe = 1'b0, prev_resend = 1'b0;
    logic in_frame = 1'b0, first_pending = 1'b0, frame_valid = 1'b0, exp_com7 = 1'b0;
    int   nbits = 0, start_cyc = 0, resend_cyc = 0, resend_cnt = 0, adv_cnt = 0;
    logic bits [32];

    always @(negedge clk) begin
        if (rst) begin
            in_frame    = 1'b0;
            nbits       = 0;
            frame_valid = 1'b0;
        end else begin
            if (resend && !prev_resend) begin
                resend_cnt++;
                resend_cyc    = cyc;
                first_pending = 1'b1;
            end
            if (!resend && prev_resend) chk("resend_width", cyc - resend_cyc, 1);

            if (advance) begin
                adv_cnt++;
                if (frame_valid) begin
                    chk("start_to_advance", cyc - start_cyc,
                        START_TO_ADV + (exp_com7 ? SOFT_DLY : 0));
                    frame_valid = 1'b0;
                end
            end

            // any SIOD change while SIOC is high must be a legal start or stop
            if (sioc && siod_oe && !prev_oe) begin
                chk("start_outside_frame", int'(in_frame), 0);
                in_frame  = 1'b1;
                nbits     = 0;
                start_cyc = cyc;
                if (first_pending) begin
                    chk("resend_to_start", cyc - resend_cyc, RESEND_TO_SDA);
                    first_pending = 1'b0;
                end
            end else if (sioc && !siod_oe && prev_oe) begin
                chk("stop_position", in_frame ? nbits : -1, 28);
                if (in_frame && nbits == 28) begin
                    logic [23:0] got, e;
                    got = '0;
                    for (int b = 0; b < 3; b++)
                        for (int i = 0; i < 8; i++)
                            got[23 - 8*b - i] = bits[9*b + i];
                    chk("ack_slots_released", {29'd0, bits[8], bits[17], bits[26]}, 7);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(got), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_bytes", int'(got), int'(e));
                        exp_com7    = (e[15:8] == 8'h12) && e[7];
                        frame_valid = 1'b1;
                    end
                end
                in_frame = 1'b0;
            end

            if (sioc && !prev_sioc && in_frame && nbits < 32) begin
                bits[nbits] = !siod_oe;
                nbits++;
            end
        end
        prev_sioc   = sioc;
        prev_oe     = siod_oe;
        prev_resend = resend;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic push_table();
        exp_q.push_back(24'h60FF01);
        exp_q.push_back(24'h601280);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic wait_bits(input int k);
        int n = 0;
        while (!(in_frame && nbits >= k && !sioc) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("bits_reached", (nbits >= k) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sioc", int'(sioc), 1);
        chk("rst_siod_oe", int'(siod_oe), 0);
        chk("rst_resend", int'(resend), 0);
        chk("rst_advance", int'(advance), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        @(negedge clk) rst = 1'b0;

        // run 1: full table
        push_table();
        pulse_start();
        wait_done();
        chk("r1_wr_count", int'(wr_count), 2);
        chk("r1_busy", int'(busy), 0);
        chk("r1_adv_cnt", adv_cnt, 2);
        chk("r1_resend_cnt", resend_cnt, 1);
        chk("r1_queue_empty", exp_q.size(), 0);

        // run 2: start from DONE clears done/wr_count; start mid-frame ignored
        push_table();
        pulse_start();
        chk("r2_busy", int'(busy), 1);
        chk("r2_done_cleared", int'(done), 0);
        chk("r2_wr_cleared", int'(wr_count), 0);
        wait_bits(5);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("r2_midstart_wr", int'(wr_count), 0);
        chk("r2_midstart_resend", resend_cnt, 2);
        wait_done();
        chk("r2_wr_count", int'(wr_count), 2);
        chk("r2_adv_cnt", adv_cnt, 4);

        // run 3: reset at bit 13 of the first frame, then full restart
        pulse_start();
        wait_bits(13);
        #2 rst = 1'b1;
        #1;
        chk("abort_sioc", int'(sioc), 1);
        chk("abort_siod_oe", int'(siod_oe), 0);
        repeat (2) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_count", int'(wr_count), 0);
        rst = 1'b0;
        push_table();
        pulse_start();
        wait_done();
        chk("r3_wr_count", int'(wr_count), 2);
        chk("r3_resend_cnt", resend_cnt, 4);
        chk("r3_adv_cnt", adv_cnt, 6);
        chk("r3_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
